ball_release_scheduler: RTL and testbench

- Clocked sequencer for the marble board.
- Owns the blue and red ball reservoirs and releases exactly one ball at a time.
- Waits for each ball to land on a bottom lever (blue/red trigger) or an interceptor, then schedules the next release by lever colour.
- Drives the board's blue_ball/red_ball release strobes and exposes stopped/no_balls/tray status to puzzle-level modules such as the geared-bit puzzles.

---
 rtl/ball_release_scheduler_if.sv | 32 +++
 rtl/ball_release_scheduler.sv | 120 ++++++++++++
 tb/tb_ball_release_scheduler.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ball_release_scheduler_if.sv
// ball_release_scheduler_if: lever/trigger inputs and release/status outputs of the ball scheduler.
interface ball_release_scheduler_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             blue_trigger;
    logic             red_trigger;
    logic             intercept;
    logic             reload;
    logic             blue_ball;
    logic             red_ball;
    logic             current_color;
    logic             busy;
    logic             stopped;
    logic             no_balls;
    logic             timeout_err;
    logic [CNT_W-1:0] blue_left;
    logic [CNT_W-1:0] red_left;
    logic [CNT_W:0]   tray_amount;

    modport master (
        output start, blue_trigger, red_trigger, intercept, reload,
        input  blue_ball, red_ball, current_color, busy, stopped, no_balls, timeout_err,
        input  blue_left, red_left, tray_amount
    );

    modport slave (
        input  start, blue_trigger, red_trigger, intercept, reload,
        output blue_ball, red_ball, current_color, busy, stopped, no_balls, timeout_err,
        output blue_left, red_left, tray_amount
    );
endinterface

// File: rtl/ball_release_scheduler.sv
// ball_release_scheduler: one-ball-at-a-time release sequencer for the marble board.
module ball_release_scheduler #(
    parameter int BLUE_BALLS     = 8,
    parameter int RED_BALLS      = 8,
    parameter int CNT_W          = 4,
    parameter int TRAVEL_TIMEOUT = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    ball_release_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RELEASE, FLIGHT, STOPPED} state_t;

    localparam int               TW        = $clog2(TRAVEL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] BLUE_FULL = CNT_W'(BLUE_BALLS);
    localparam logic [CNT_W-1:0] RED_FULL  = CNT_W'(RED_BALLS);
    localparam logic [TW-1:0]    LAST_TICK = TW'(TRAVEL_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] blue_q, blue_d, red_q, red_d;
    logic [CNT_W:0]   tray_q, tray_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             color_q, color_d, no_balls_q, no_balls_d, timeout_q, timeout_d;
    logic             busy, land_red, land_avail;

    assign busy       = state_q == RELEASE || state_q == FLIGHT;
    assign land_red   = !bus.blue_trigger;
    assign land_avail = land_red ? red_q != '0 : blue_q != '0;

    always_comb begin
        state_d    = state_q;
        blue_d     = blue_q;
        red_d      = red_q;
        tray_d     = tray_q;
        timer_d    = timer_q;
        color_d    = color_q;
        no_balls_d = no_balls_q;
        timeout_d  = timeout_q;
        if (bus.reload && !busy) begin
            state_d    = IDLE;
            blue_d     = BLUE_FULL;
            red_d      = RED_FULL;
            tray_d     = '0;
            no_balls_d = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    if (blue_q != '0) begin
                        state_d = RELEASE;
                        color_d = 1'b0;
                        blue_d  = blue_q - CNT_W'(1);
                    end else begin
                        state_d    = STOPPED;
                        no_balls_d = 1'b1;
                    end
                end
                RELEASE: begin
                    state_d = FLIGHT;
                    timer_d = '0;
                end
                FLIGHT: begin
                    timer_d = timer_q + TW'(1);
                    if (bus.intercept) begin
                        state_d = STOPPED;
                    end else if (bus.blue_trigger || bus.red_trigger) begin
                        tray_d = tray_q + (CNT_W + 1)'(tray_q != '1);
                        // the landing lever's colour picks the next ball
                        if (land_avail) begin
                            state_d = RELEASE;
                            color_d = land_red;
                            blue_d  = land_red ? blue_q : blue_q - CNT_W'(1);
                            red_d   = land_red ? red_q - CNT_W'(1) : red_q;
                        end else begin
                            state_d    = STOPPED;
                            no_balls_d = 1'b1;
                        end
                    end else if (timer_q == LAST_TICK) begin
                        state_d   = STOPPED;
                        timeout_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            blue_q     <= BLUE_FULL;
            red_q      <= RED_FULL;
            tray_q     <= '0;
            timer_q    <= '0;
            color_q    <= 1'b0;
            no_balls_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            blue_q     <= blue_d;
            red_q      <= red_d;
            tray_q     <= tray_d;
            timer_q    <= timer_d;
            color_q    <= color_d;
            no_balls_q <= no_balls_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.blue_ball     = state_q == RELEASE && !color_q;
    assign bus.red_ball      = state_q == RELEASE && color_q;
    assign bus.current_color = color_q;
    assign bus.busy          = busy;
    assign bus.stopped       = state_q == STOPPED;
    assign bus.no_balls      = no_balls_q;
    assign bus.timeout_err   = timeout_q;
    assign bus.blue_left     = blue_q;
    assign bus.red_left      = red_q;
    assign bus.tray_amount   = tray_q;
endmodule

// File: tb/tb_ball_release_scheduler.sv
// tb_ball_release_scheduler: directed table, corner sequences and randomized run against a ball-level model.
module tb_ball_release_scheduler;
    localparam int CNT_W = 4;
    localparam int TO    = 16;
    localparam int TMAX  = (1 << (CNT_W + 1)) - 1;

    localparam logic [4:0] ST = 5'b10000, BT = 5'b01000, RT = 5'b00100, IC = 5'b00010, RL = 5'b00001, NO = 5'b00000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ball_release_scheduler_if #(.CNT_W(CNT_W)) bus ();
    ball_release_scheduler_if #(.CNT_W(CNT_W)) bus2 ();

    ball_release_scheduler #(.BLUE_BALLS(8), .RED_BALLS(8), .CNT_W(CNT_W), .TRAVEL_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    ball_release_scheduler #(.BLUE_BALLS(2), .RED_BALLS(8), .CNT_W(CNT_W), .TRAVEL_TIMEOUT(TO)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_pass = 0;
    int n_total = 0;

    // ball-level model: which ball is being strobed, whether one is rolling, and how long it has rolled
    int m_left[2];
    int m_tray, m_rel, m_age;
    bit m_fly, m_halt, m_nob, m_to, m_col;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_left[0] = 8; m_left[1] = 8; m_tray = 0; m_rel = -1; m_age = 0;
        m_fly = 0; m_halt = 0; m_nob = 0; m_to = 0; m_col = 0;
    endtask

    task automatic model_refill();
        m_left[0] = 8; m_left[1] = 8; m_tray = 0; m_nob = 0; m_to = 0; m_halt = 0;
    endtask

    task automatic model_launch(input int c);
        if (m_left[c] > 0) begin
            m_left[c]--;
            m_col = c[0];
            m_rel = c;
        end else begin
            m_halt = 1;
            m_nob = 1;
        end
    endtask

    task automatic model_edge(input logic [4:0] in);
        if (m_rel >= 0) begin
            m_rel = -1; m_fly = 1; m_age = 0;
        end else if (m_fly) begin
            if (in[1]) begin
                m_fly = 0; m_halt = 1;
            end else if (in[3] || in[2]) begin
                m_fly = 0;
                m_tray = (m_tray + 1 > TMAX) ? TMAX : m_tray + 1;
                model_launch(in[3] ? 0 : 1);
            end else if (m_age == TO - 1) begin
                m_fly = 0; m_halt = 1; m_to = 1;
            end else m_age++;
        end else if (m_halt) begin
            if (in[0]) model_refill();
        end else if (in[0]) model_refill();
        else if (in[4]) model_launch(0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " blue_ball"}, int'(bus.blue_ball), int'(m_rel == 0));
        chk({tag, " red_ball"}, int'(bus.red_ball), int'(m_rel == 1));
        chk({tag, " busy"}, int'(bus.busy), int'(m_rel >= 0 || m_fly));
        chk({tag, " stopped"}, int'(bus.stopped), int'(m_halt));
        chk({tag, " no_balls"}, int'(bus.no_balls), int'(m_nob));
        chk({tag, " timeout_err"}, int'(bus.timeout_err), int'(m_to));
        chk({tag, " current_color"}, int'(bus.current_color), int'(m_col));
        chk({tag, " blue_left"}, int'(bus.blue_left), m_left[0]);
        chk({tag, " red_left"}, int'(bus.red_left), m_left[1]);
        chk({tag, " tray_amount"}, int'(bus.tray_amount), m_tray);
    endtask

    task automatic step(input logic [4:0] in);
        @(negedge clk);
        {bus.start, bus.blue_trigger, bus.red_trigger, bus.intercept, bus.reload} = in;
        @(posedge clk);
        model_edge(in);
        #1;
    endtask

    task automatic step2(input logic [4:0] in);
        @(negedge clk);
        {bus2.start, bus2.blue_trigger, bus2.red_trigger, bus2.intercept, bus2.reload} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        {bus.start, bus.blue_trigger, bus.red_trigger, bus.intercept, bus.reload} = NO;
        {bus2.start, bus2.blue_trigger, bus2.red_trigger, bus2.intercept, bus2.reload} = NO;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [4:0] in;
        bit         bb, rb, busy, stop;
        int         bl, rl, tray;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{ST,      1, 0, 1, 0, 7, 8, 0};
        tbl[1]  = '{NO,      0, 0, 1, 0, 7, 8, 0};
        tbl[2]  = '{NO,      0, 0, 1, 0, 7, 8, 0};
        tbl[3]  = '{BT,      1, 0, 1, 0, 6, 8, 1};
        tbl[4]  = '{NO,      0, 0, 1, 0, 6, 8, 1};
        tbl[5]  = '{RT,      0, 1, 1, 0, 6, 7, 2};
        tbl[6]  = '{NO,      0, 0, 1, 0, 6, 7, 2};
        tbl[7]  = '{IC | BT, 0, 0, 0, 1, 6, 7, 2};
        tbl[8]  = '{ST,      0, 0, 0, 1, 6, 7, 2};
        tbl[9]  = '{RL,      0, 0, 0, 0, 8, 8, 0};
        tbl[10] = '{ST | RL, 0, 0, 0, 0, 8, 8, 0};
        tbl[11] = '{BT,      0, 0, 0, 0, 8, 8, 0};

        do_reset();
        #1;
        chk("reset blue_left", int'(bus.blue_left), 8);
        chk("reset red_left", int'(bus.red_left), 8);
        chk("reset tray", int'(bus.tray_amount), 0);
        chk("reset flags", int'({bus.busy, bus.stopped, bus.no_balls, bus.timeout_err, bus.current_color}), 0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].in);
            chk($sformatf("vec%0d blue_ball", i), int'(bus.blue_ball), int'(tbl[i].bb));
            chk($sformatf("vec%0d red_ball", i), int'(bus.red_ball), int'(tbl[i].rb));
            chk($sformatf("vec%0d busy", i), int'(bus.busy), int'(tbl[i].busy));
            chk($sformatf("vec%0d stopped", i), int'(bus.stopped), int'(tbl[i].stop));
            chk($sformatf("vec%0d blue_left", i), int'(bus.blue_left), tbl[i].bl);
            chk($sformatf("vec%0d red_left", i), int'(bus.red_left), tbl[i].rl);
            chk($sformatf("vec%0d tray", i), int'(bus.tray_amount), tbl[i].tray);
            if (i == 5) chk("vec5 current_color", int'(bus.current_color), 1);
        end

        do_reset();
        step(ST);
        repeat (16) step(NO);
        chk("timeout still busy", int'(bus.busy), 1);
        step(NO);
        chk("timeout stopped", int'(bus.stopped), 1);
        chk("timeout err", int'(bus.timeout_err), 1);
        chk("timeout tray", int'(bus.tray_amount), 0);
        step(RL);
        chk("timeout reload stopped", int'(bus.stopped), 0);
        chk("timeout reload err", int'(bus.timeout_err), 0);
        chk("timeout reload blue_left", int'(bus.blue_left), 8);

        do_reset();
        step(ST);
        repeat (16) step(NO);
        step(BT);
        chk("late landing strobe", int'(bus.blue_ball), 1);
        chk("late landing err", int'(bus.timeout_err), 0);
        chk("late landing tray", int'(bus.tray_amount), 1);

        do_reset();
        step2(ST);
        step2(NO);
        step2(BT);
        step2(NO);
        step2(BT);
        chk("two-ball tray", int'(bus2.tray_amount), 2);
        chk("two-ball stopped", int'(bus2.stopped), 1);
        chk("two-ball no_balls", int'(bus2.no_balls), 1);
        chk("two-ball strobe", int'(bus2.blue_ball), 0);
        step2(NO);
        chk("two-ball no third strobe", int'(bus2.blue_ball), 0);

        do_reset();
        step(ST);
        step(NO);
        step(BT);
        step(NO);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async blue_left", int'(bus.blue_left), 8);
        chk("async tray", int'(bus.tray_amount), 0);
        chk("async busy", int'(bus.busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            logic [4:0] in;
            in[4] = $urandom_range(0, 99) < 25;
            in[3] = $urandom_range(0, 99) < 12;
            in[2] = $urandom_range(0, 99) < 12;
            in[1] = $urandom_range(0, 99) < 3;
            in[0] = $urandom_range(0, 99) < 6;
            step(in);
            check_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
